// File: rtl/bip_mem_datapath.sv
// BIP accumulator datapath: runs LD/ST/ALU ops from the control unit
// against a data memory that has a 1-cycle synchronous read.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   op_valid/op_ready   op handshake (accept = op_valid & op_ready)
//   op_code, operand    opcode and address/immediate, sampled on accept
//   done                1-cycle pulse when an op has completed
//   halted              sticky after HLT until reset
//   acc                 accumulator
//   addr_data, in_data  data memory address and write data (in_data = acc)
//   write               data memory write enable
//   out_data            data memory read data, valid one cycle after
//                       addr_data is sampled
module bip_mem_datapath #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [4:0]        op_code,
  input  logic [ADDR_W-1:0] operand,
  output logic              op_ready,
  output logic              done,
  output logic              halted,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] addr_data,
  output logic [DATA_W-1:0] in_data,
  output logic              write,
  input  logic [DATA_W-1:0] out_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    HALT
  } state_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  // Which memory op is in flight while we wait for out_data.
  typedef enum logic [1:0] {
    MEM_LD,
    MEM_ADD,
    MEM_SUB
  } mem_op_t;

  state_t  state, state_nx;
  mem_op_t mop, mop_nx;

  logic [DATA_W-1:0] acc_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              done_nx;
  logic              accept;
  logic [DATA_W-1:0] imm;

  logic is_hlt, is_sto, is_mem;
  logic is_ldi, is_addi, is_subi;

  assign accept = op_valid & op_ready;

  assign imm = {{(DATA_W-ADDR_W){operand[ADDR_W-1]}}, operand};

  assign is_hlt  = (op_code == OP_HLT);
  assign is_sto  = (op_code == OP_STO);
  assign is_mem  = (op_code == OP_LD)
                 | (op_code == OP_ADD)
                 | (op_code == OP_SUB);
  assign is_ldi  = (op_code == OP_LDI);
  assign is_addi = (op_code == OP_ADDI);
  assign is_subi = (op_code == OP_SUBI);

  always_comb begin
    state_nx = state;
    mop_nx   = mop;
    acc_nx   = acc;
    addr_nx  = addr_data;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_hlt: begin
              state_nx = HALT;
              done_nx  = 1'b1;
            end
            is_sto: begin
              addr_nx  = operand;
              state_nx = WR;
            end
            is_mem: begin
              addr_nx  = operand;
              state_nx = RD_ADDR;
              if (op_code == OP_LD)
                mop_nx = MEM_LD;
              else if (op_code == OP_ADD)
                mop_nx = MEM_ADD;
              else
                mop_nx = MEM_SUB;
            end
            is_ldi: begin
              acc_nx  = imm;
              done_nx = 1'b1;
            end
            is_addi: begin
              acc_nx  = acc + imm;
              done_nx = 1'b1;
            end
            is_subi: begin
              acc_nx  = acc - imm;
              done_nx = 1'b1;
            end
            default: done_nx = 1'b1;
          endcase
        end
      end
      // Memory samples addr_data on the edge leaving this state.
      RD_ADDR: state_nx = RD_DATA;
      RD_DATA: begin
        unique case (mop)
          MEM_LD:  acc_nx = out_data;
          MEM_ADD: acc_nx = acc + out_data;
          default: acc_nx = acc - out_data;
        endcase
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      WR: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mop       <= MEM_LD;
      acc       <= '0;
      addr_data <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      mop       <= mop_nx;
      acc       <= acc_nx;
      addr_data <= addr_nx;
      done      <= done_nx;
    end
  end

  // Decoded straight from the state register, so reset clears
  // them the same cycle and no stray write can follow reset.
  assign op_ready = (state == IDLE);
  assign write    = (state == WR);
  assign halted   = (state == HALT);
  assign in_data  = acc;

endmodule

// File: tb/tb_bip_mem_datapath.sv
// Scoreboard bench for bip_mem_datapath with a behavioural data memory.
// Drivers push expected done/write events; a negedge monitor checks them.
module tb_bip_mem_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [4:0]  op_code = '0;
  logic [10:0] operand = '0;
  logic        op_ready;
  logic        done;
  logic        halted;
  logic [15:0] acc;
  logic [10:0] addr_data;
  logic [15:0] in_data;
  logic        write;
  logic [15:0] out_data;

  bip_mem_datapath #(.DATA_W(16), .ADDR_W(11)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_code  (op_code),
    .operand  (operand),
    .op_ready (op_ready),
    .done     (done),
    .halted   (halted),
    .acc      (acc),
    .addr_data(addr_data),
    .in_data  (in_data),
    .write    (write),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:2047];
  always @(posedge clk) begin
    if (write) mem[addr_data] <= in_data;
    out_data <= mem[addr_data];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] acc;
    int          cyc;
  } done_exp_t;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_exp_t;

  done_exp_t dq[$];
  wr_exp_t   wq[$];

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] HLT  = 5'b00000;
  localparam logic [4:0] STO  = 5'b00001;
  localparam logic [4:0] LD   = 5'b00010;
  localparam logic [4:0] LDI  = 5'b00011;
  localparam logic [4:0] ADD  = 5'b00100;
  localparam logic [4:0] ADDI = 5'b00101;
  localparam logic [4:0] SUB  = 5'b00110;
  localparam logic [4:0] SUBI = 5'b00111;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every done/write must match the head of its queue.
  always @(negedge clk) begin
    done_exp_t d;
    wr_exp_t   w;
    if (done === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc %0d acc %h", cyc, acc);
      end else begin
        d = dq.pop_front();
        if (acc !== d.acc || cyc != d.cyc) begin
          errors++;
          $display("FAIL done got acc %h cyc %0d want acc %h cyc %0d",
                   acc, cyc, d.acc, d.cyc);
        end
      end
    end
    if (write === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected cyc %0d addr %h", cyc, addr_data);
      end else begin
        w = wq.pop_front();
        if (addr_data !== w.addr || in_data !== w.data || cyc != w.cyc) begin
          errors++;
          $display("FAIL write got %h/%h cyc %0d want %h/%h cyc %0d",
                   addr_data, in_data, cyc, w.addr, w.data, w.cyc);
        end
      end
    end
  end

  // Presents one op, waits (bounded) for acceptance, then scrambles
  // the op inputs to show they are not used after the accept edge.
  task automatic issue(input logic [4:0] c, input logic [10:0] opd,
                       input logic [15:0] exp, input int lat,
                       input bit expect_done);
    int n = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = c;
    operand  = opd;
    while (op_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, op_ready}, 32'd1);
    if (expect_done) begin
      dq.push_back('{acc: exp, cyc: cyc + lat});
      if (c == STO) wq.push_back('{addr: opd, data: exp, cyc: cyc + 1});
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = 5'($urandom);
    operand  = 11'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    @(negedge clk);
    chk({nm, "_acc"}, {16'd0, acc}, 32'd0);
    chk({nm, "_write"}, {31'd0, write}, 32'd0);
    chk({nm, "_ready"}, {31'd0, op_ready}, 32'd1);
    chk({nm, "_halted"}, {31'd0, halted}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((dq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("queues_drained", dq.size() + wq.size(), 32'd0);
  endtask

  initial begin
    do_reset();
    chk_idle("reset");
    chk("reset_addr", {21'd0, addr_data}, 32'd0);

    issue(LDI, 11'h005, 16'h0005, 1, 1);
    issue(STO, 11'h010, 16'h0005, 2, 1);
    issue(LD,  11'h010, 16'h0005, 3, 1);
    @(negedge clk);
    chk("ld_ready_c1", {31'd0, op_ready}, 32'd0);
    @(negedge clk);
    chk("ld_ready_c2", {31'd0, op_ready}, 32'd0);
    @(negedge clk);
    chk("ld_ready_c3", {31'd0, op_ready}, 32'd1);

    issue(LDI,  11'h3FF, 16'h03FF, 1, 1);
    issue(ADDI, 11'h3FF, 16'h07FE, 1, 1);
    issue(ADDI, 11'h002, 16'h0800, 1, 1);
    issue(LDI,  11'h000, 16'h0000, 1, 1);
    issue(SUBI, 11'h7FF, 16'h0001, 1, 1);
    issue(LDI,  11'h7FF, 16'hFFFF, 1, 1);
    issue(STO,  11'h020, 16'hFFFF, 2, 1);
    issue(ADDI, 11'h001, 16'h0000, 1, 1);
    issue(LDI,  11'h002, 16'h0002, 1, 1);
    issue(ADD,  11'h020, 16'h0001, 3, 1);
    issue(LDI,  11'h002, 16'h0002, 1, 1);
    issue(SUB,  11'h020, 16'h0003, 3, 1);
    issue(5'b01000, 11'h055, 16'h0003, 1, 1);
    issue(5'b11111, 11'h7AA, 16'h0003, 1, 1);
    issue(STO,  11'h7FF, 16'h0003, 2, 1);
    issue(LD,   11'h7FF, 16'h0003, 3, 1);
    issue(HLT,  11'h000, 16'h0003, 1, 1);

    @(negedge clk);
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    chk("hlt_ready", {31'd0, op_ready}, 32'd0);
    op_valid = 1'b1;
    op_code  = LDI;
    operand  = 11'h123;
    repeat (5) @(negedge clk);
    op_valid = 1'b0;
    chk("hlt_acc_kept", {16'd0, acc}, 32'h0003);
    chk("hlt_sticky", {31'd0, halted}, 32'd1);
    drain();

    do_reset();
    chk_idle("reset2");

    issue(LDI, 11'h00A, 16'h000A, 1, 1);
    issue(LD, 11'h020, 16'h0000, 3, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk_idle("abort");
    repeat (4) @(negedge clk);
    chk("abort_acc_held", {16'd0, acc}, 32'd0);

    issue(LDI, 11'h001, 16'h0001, 1, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
